// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg -- shared register-file writeback types and constants (rev 1.0)
`default_nettype none

package wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// wb_fifo -- memory-result FIFO with per-entry destination visibility (rev 1.0)
`default_nettype none

module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic [NUM_REGS-1:0]   pend_mask
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wptr, rptr;
  logic [REG_ADDR_W-1:0]   rd_mem   [DEPTH];
  logic [XLEN-1:0]         data_mem [DEPTH];
  logic [DEPTH-1:0]        valid;
  logic                    do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem[rptr[AW-1:0]];
  assign head_data = data_mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        valid[wptr[AW-1:0]] <= 1'b1;
        wptr                <= wptr + 1'b1;
      end
      if (do_pop) begin
        valid[rptr[AW-1:0]] <= 1'b0;
        rptr                <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wptr[AW-1:0]]   <= push_rd;
      data_mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend_mask[rd_mem[i]] = 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// wb_arbiter -- merges ALU and buffered memory results onto the register-file write port (rev 1.0)
// Optional macro WB_BYPASS_EN adds same-cycle write-to-read forwarding ports.
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       writeData,
  output logic                  regWrite,
  output logic [NUM_REGS-1:0]   pend_mask
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`endif
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic                  full, empty, push, pop, starve, alu_issue;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CW-1:0]         cnt;

  // Writes to x0 are swallowed at intake so they never occupy a slot.
  assign mem_ready = !full;
  assign push      = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign starve    = (cnt == CW'(STARVE_MAX));
  assign alu_stall = alu_valid && (alu_rd != REG_ZERO) && (pend_mask[alu_rd] || starve);
  assign alu_issue = alu_valid && (alu_rd != REG_ZERO) && !alu_stall;
  assign pop       = !alu_issue && !empty;

  wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .pend_mask (pend_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      rd        <= REG_ZERO;
      writeData <= '0;
      cnt       <= '0;
    end else begin
      regWrite <= alu_issue || pop;
      if (alu_issue) begin
        rd        <= alu_rd;
        writeData <= alu_data;
      end else if (pop) begin
        rd        <= head_rd;
        writeData <= head_data;
      end
      if (empty || pop)
        cnt <= '0;
      else if (alu_issue && !starve)
        cnt <= cnt + 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_data1 = (regWrite && rd == rs1 && rs1 != REG_ZERO) ? writeData : rf_data1;
  assign fwd_data2 = (regWrite && rd == rs2 && rs2 != REG_ZERO) ? writeData : rf_data2;
`endif
endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- directed and randomized checks of wb_arbiter against a queue-based model (rev 1.0)
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk, reset;
  logic        alu_valid, alu_stall, mem_valid, mem_ready, regWrite;
  logic [4:0]  alu_rd, mem_rd, rd;
  logic [31:0] alu_data, mem_data, writeData, pend_mask;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd(rd), .writeData(writeData), .regWrite(regWrite), .pend_mask(pend_mask)
`ifdef WB_BYPASS_EN
    , .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of buffered results plus a count of lost arbitrations.
  wb_entry     q[$];
  int          losses;
  logic        exp_rw;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;
  logic        m_stall, m_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m = m | (32'd1 << q[i].rd);
    return m;
  endfunction

  task automatic check_regs();
    check("regWrite", {63'd0, regWrite}, {63'd0, exp_rw});
    check("rd", {59'd0, rd}, {59'd0, exp_rd});
    check("writeData", {32'd0, writeData}, {32'd0, exp_wd});
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete(); losses = 0;
    exp_rw = 1'b0; exp_rd = '0; exp_wd = '0;
    m_stall = 1'b0; m_ready = 1'b1;
    check_regs();
    #1;
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    check("rst_pend_mask", {32'd0, pend_mask}, 64'd0);
    check("rst_alu_stall", {63'd0, alu_stall}, 64'd0);
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic [31:0] mask;
    logic        starve;
    wb_entry     e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    mask    = model_mask();
    m_ready = (q.size() < DEPTH);
    starve  = (losses >= STARVE_MAX);
    m_stall = av && (ard != 5'd0) && (mask[ard] || starve);
    check("mem_ready", {63'd0, mem_ready}, {63'd0, m_ready});
    check("pend_mask", {32'd0, pend_mask}, {32'd0, mask});
    check("alu_stall", {63'd0, alu_stall}, {63'd0, m_stall});
    if (av && ard != 5'd0 && !m_stall) begin
      exp_rw = 1'b1; exp_rd = ard; exp_wd = ad;
      losses = (q.size() == 0) ? 0 : ((losses < STARVE_MAX) ? losses + 1 : losses);
    end else if (q.size() != 0) begin
      e = q.pop_front();
      exp_rw = 1'b1; exp_rd = e.rd; exp_wd = e.data;
      losses = 0;
    end else begin
      exp_rw = 1'b0;
      losses = 0;
    end
    if (mv && m_ready && mrd != 5'd0) begin
      e.rd = mrd; e.data = md;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  logic        r_av, r_mv;
  logic [4:0]  r_ard, r_mrd;
  logic [31:0] r_ad, r_md;
  int          k;

  initial begin
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
    rs1 = '0; rs2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif
    do_reset(2);

    // ALU write, then a dropped write to x0
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("alu_rd5", {59'd0, rd}, 64'd5);
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    check("alu_x0_no_write", {63'd0, regWrite}, 64'd0);

    // Memory result: visible in pend_mask, written two edges after push
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    check("pend_after_push", {32'd0, pend_mask}, 64'h80);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("mem_rd7_data", {32'd0, writeData}, 64'h11);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Hazard on x3: memory write must precede the ALU write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0);
    check("hazard_stall", {63'd0, m_stall}, 64'd1);
    check("hazard_mem_first", {32'd0, writeData}, 64'h33);
    step(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0);
    check("hazard_alu_second", {32'd0, writeData}, 64'hA3);

    // Fill FIFO under continuous ALU traffic; starvation limit forces pops
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 5'd9, 32'h900 + i, 1'b1, 5'(10 + k), 32'hB00 + k);
      if (m_ready) k++;
    end

    // Reset mid-operation discards buffered entries
    step(1'b1, 5'd9, 32'h1, 1'b1, 5'd12, 32'hC1);
    step(1'b1, 5'd9, 32'h2, 1'b1, 5'd13, 32'hC2);
    do_reset(1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("post_reset_idle", {63'd0, regWrite}, 64'd0);

`ifdef WB_BYPASS_EN
    step(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0);
    rs1 = 5'd4; rf_data1 = 32'h0; rs2 = 5'd6; rf_data2 = 32'h66;
    #1;
    check("fwd1_hit", {32'd0, fwd_data1}, 64'h55);
    check("fwd2_miss", {32'd0, fwd_data2}, 64'h66);
    rs1 = 5'd0; rf_data1 = 32'h77;
    #1;
    check("fwd1_x0", {32'd0, fwd_data1}, 64'h77);
`endif

    // Randomized traffic; stalled/unaccepted producers hold their outputs
    r_av = 1'b0; r_mv = 1'b0; r_ard = '0; r_mrd = '0; r_ad = '0; r_md = '0;
    m_stall = 1'b0; m_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (!(r_av && m_stall)) begin
        r_av  = ($urandom_range(0, 3) != 0);
        r_ard = 5'($urandom_range(0, 7));
        r_ad  = $urandom;
      end
      if (!(r_mv && !m_ready)) begin
        r_mv  = ($urandom_range(0, 1) != 0);
        r_mrd = 5'($urandom_range(0, 7));
        r_md  = $urandom;
      end
      step(r_av, r_ard, r_ad, r_mv, r_mrd, r_md);
    end

    // Drain
    for (int n = 0; n < 4; n++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("drained", {32'd0, pend_mask}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
